// File: rtl/a2bus_dout_arbiter.sv
// Apple II bus read-data / IRQ arbiter: fixed-priority card grant with locked bus cycles,
// post-cycle output-enable hold, contention detection/counting and masked IRQ aggregation.
module a2bus_dout_arbiter #(
    parameter int unsigned NUM_CARDS   = 3,
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned HOLD_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned IRQ_ENABLE  = 1
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            phi1_posedge_i,
    input  logic [NUM_CARDS-1:0]            card_rd_en_i,
    input  logic [NUM_CARDS*DATA_WIDTH-1:0] card_data_i,
    input  logic [NUM_CARDS-1:0]            card_irq_n_i,
    input  logic [NUM_CARDS-1:0]            irq_mask_i,
    input  logic [DATA_WIDTH-1:0]           default_data_i,
    input  logic                            clear_count_i,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            data_oe_o,
    output logic [NUM_CARDS-1:0]            grant_o,
    output logic                            irq_n_o,
    output logic [NUM_CARDS-1:0]            irq_pending_o,
    output logic                            contention_o,
    output logic [CNT_WIDTH-1:0]            contention_count_o
);

    localparam int unsigned IDX_W  = (NUM_CARDS > 1) ? $clog2(NUM_CARDS) : 1;
    localparam int unsigned HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [HOLD_W-1:0]     hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0]      gidx_q, gidx_d;
    logic [NUM_CARDS-1:0]  grant_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  oe_d;
    logic                  contention_c;

    logic [IDX_W-1:0]      win_idx;
    logic [NUM_CARDS-1:0]  win_onehot;
    logic [DATA_WIDTH-1:0] win_data;
    logic [DATA_WIDTH-1:0] cur_data;
    logic                  any_rd;
    logic                  multi_rd;
    logic                  granted_rd;
    logic                  other_rd;
    logic [NUM_CARDS-1:0]  pending_c;

    // Lowest set request index wins
    always_comb begin
        win_idx    = '0;
        win_onehot = '0;
        for (int i = int'(NUM_CARDS) - 1; i >= 0; i--) begin
            if (card_rd_en_i[i]) begin
                win_idx       = IDX_W'(i);
                win_onehot    = '0;
                win_onehot[i] = 1'b1;
            end
        end
    end

    // Card data for the new winner and for the currently locked grant
    always_comb begin
        win_data = '0;
        cur_data = '0;
        for (int i = 0; i < int'(NUM_CARDS); i++) begin
            if (win_idx == IDX_W'(i)) win_data = card_data_i[i*DATA_WIDTH +: DATA_WIDTH];
            if (gidx_q == IDX_W'(i))  cur_data = card_data_i[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign any_rd     = |card_rd_en_i;
    assign multi_rd   = |(card_rd_en_i & (card_rd_en_i - NUM_CARDS'(1)));
    assign granted_rd = |(card_rd_en_i & grant_o);
    assign other_rd   = |(card_rd_en_i & ~grant_o);
    assign pending_c  = ~card_irq_n_i & irq_mask_i;

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        gidx_d       = gidx_q;
        grant_d      = grant_o;
        data_d       = data_o;
        oe_d         = data_oe_o;
        contention_c = 1'b0;

        case (state_q)
            IDLE, HOLD: begin
                contention_c = multi_rd;
                if (any_rd) begin
                    // A request during HOLD aborts the hold exactly like a fresh grant
                    state_d    = GRANT;
                    grant_d    = win_onehot;
                    gidx_d     = win_idx;
                    data_d     = win_data;
                    oe_d       = 1'b1;
                    hold_cnt_d = '0;
                end else if (state_q == IDLE || hold_cnt_q <= HOLD_W'(1)) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    data_d     = default_data_i;
                    oe_d       = 1'b0;
                    hold_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLD_W'(1);
                end
            end
            GRANT: begin
                contention_c = other_rd;
                if (!granted_rd) begin
                    grant_d = '0;
                    if (HOLD_CYCLES > 0) begin
                        state_d    = HOLD;
                        hold_cnt_d = HOLD_W'(HOLD_CYCLES);
                    end else begin
                        state_d = IDLE;
                        data_d  = default_data_i;
                        oe_d    = 1'b0;
                    end
                end else if (phi1_posedge_i) begin
                    // End of bus cycle: lock released, winner recomputed from live requests
                    grant_d = win_onehot;
                    gidx_d  = win_idx;
                    data_d  = win_data;
                end else begin
                    data_d = cur_data;
                end
            end
            default: begin
                state_d    = IDLE;
                grant_d    = '0;
                data_d     = default_data_i;
                oe_d       = 1'b0;
                hold_cnt_d = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            hold_cnt_q         <= '0;
            gidx_q             <= '0;
            grant_o            <= '0;
            data_o             <= '0;
            data_oe_o          <= 1'b0;
            contention_o       <= 1'b0;
            contention_count_o <= '0;
            irq_pending_o      <= '0;
            irq_n_o            <= 1'b1;
        end else begin
            state_q       <= state_d;
            hold_cnt_q    <= hold_cnt_d;
            gidx_q        <= gidx_d;
            grant_o       <= grant_d;
            data_o        <= data_d;
            data_oe_o     <= oe_d;
            contention_o  <= contention_c;
            irq_pending_o <= pending_c;
            irq_n_o       <= (IRQ_ENABLE != 0) ? ~(|pending_c) : 1'b1;
            if (contention_c) begin
                if (clear_count_i)
                    contention_count_o <= CNT_WIDTH'(1);
                else if (!(&contention_count_o))
                    contention_count_o <= contention_count_o + CNT_WIDTH'(1);
            end else if (clear_count_i) begin
                contention_count_o <= '0;
            end
        end
    end

endmodule

// File: tb/tb_a2bus_dout_arbiter.sv
// Scoreboard bench for a2bus_dout_arbiter: directed stimulus pushes expected outputs,
// a negedge monitor pops and compares. A second instance (no hold, IRQ disabled) shares inputs.
module tb_a2bus_dout_arbiter;

    localparam logic [7:0] DEF = 8'hEE;
    localparam logic [7:0] D0  = 8'hC3;
    localparam logic [7:0] D1  = 8'hA5;
    localparam logic [7:0] D2  = 8'h5A;

    logic        clk = 1'b0;
    logic        reset;
    logic        phi1;
    logic [2:0]  rd_en;
    logic [23:0] card_data;
    logic [2:0]  irq_n_in;
    logic [2:0]  irq_mask;
    logic [7:0]  default_data;
    logic        clear_count;

    logic [7:0]  data_o, data2;
    logic        oe, oe2;
    logic [2:0]  grant, grant2;
    logic        irq_n, irq_n2;
    logic [2:0]  pend, pend2;
    logic        cont, cont2;
    logic [7:0]  cnt, cnt2;

    always #5 clk = ~clk;

    a2bus_dout_arbiter #(
        .NUM_CARDS(3), .DATA_WIDTH(8), .HOLD_CYCLES(2), .CNT_WIDTH(8), .IRQ_ENABLE(1)
    ) u_dut (
        .clk(clk), .reset(reset), .phi1_posedge_i(phi1), .card_rd_en_i(rd_en),
        .card_data_i(card_data), .card_irq_n_i(irq_n_in), .irq_mask_i(irq_mask),
        .default_data_i(default_data), .clear_count_i(clear_count),
        .data_o(data_o), .data_oe_o(oe), .grant_o(grant), .irq_n_o(irq_n),
        .irq_pending_o(pend), .contention_o(cont), .contention_count_o(cnt)
    );

    a2bus_dout_arbiter #(
        .NUM_CARDS(3), .DATA_WIDTH(8), .HOLD_CYCLES(0), .CNT_WIDTH(8), .IRQ_ENABLE(0)
    ) u_dut_nohold (
        .clk(clk), .reset(reset), .phi1_posedge_i(phi1), .card_rd_en_i(rd_en),
        .card_data_i(card_data), .card_irq_n_i(irq_n_in), .irq_mask_i(irq_mask),
        .default_data_i(default_data), .clear_count_i(clear_count),
        .data_o(data2), .data_oe_o(oe2), .grant_o(grant2), .irq_n_o(irq_n2),
        .irq_pending_o(pend2), .contention_o(cont2), .contention_count_o(cnt2)
    );

    typedef struct {
        int         tag;
        int         due;
        logic [7:0] data;
        logic       oe;
        logic [2:0] grant;
        logic       irq_n;
        logic [2:0] pend;
        logic       cont;
        logic [7:0] cnt;
        logic [7:0] data2;
        logic       oe2;
    } exp_t;

    exp_t e;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    // Shadow inputs, copied onto the DUT inputs at the next negedge by step()
    logic [2:0]  s_rd, s_irq_n, s_mask;
    logic        s_phi1, s_clr, s_rst;
    logic [23:0] s_data;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input int tag, input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL t%0d %s: got %h expected %h (cycle %0d)", tag, nm, act, exp, cyc);
        end
    endtask

    task automatic step(input int tag, input bit in_hold);
        exp_t t;
        @(negedge clk);
        reset       = s_rst;
        phi1        = s_phi1;
        clear_count = s_clr;
        rd_en       = s_rd;
        irq_n_in    = s_irq_n;
        irq_mask    = s_mask;
        card_data   = s_data;
        t       = e;
        t.tag   = tag;
        t.due   = cyc + 1;
        t.oe2   = in_hold ? 1'b0 : e.oe;
        t.data2 = in_hold ? DEF : e.data;
        q.push_back(t);
    endtask

    // Monitor: compare every output whose expectation is due this cycle
    always @(negedge clk) begin
        exp_t t;
        while (q.size() > 0 && q[0].due == cyc) begin
            t = q.pop_front();
            cmp(t.tag, "data_o",       data_o,           t.data);
            cmp(t.tag, "data_oe_o",    8'(oe),           8'(t.oe));
            cmp(t.tag, "grant_o",      8'(grant),        8'(t.grant));
            cmp(t.tag, "irq_n_o",      8'(irq_n),        8'(t.irq_n));
            cmp(t.tag, "irq_pending",  8'(pend),         8'(t.pend));
            cmp(t.tag, "contention_o", 8'(cont),         8'(t.cont));
            cmp(t.tag, "count",        cnt,              t.cnt);
            cmp(t.tag, "nohold.data",  data2,            t.data2);
            cmp(t.tag, "nohold.oe",    8'(oe2),          8'(t.oe2));
            cmp(t.tag, "nohold.grant", 8'(grant2),       8'(t.grant));
            cmp(t.tag, "nohold.irq_n", 8'(irq_n2),       8'h01);
            cmp(t.tag, "nohold.pend",  8'(pend2),        8'(t.pend));
            cmp(t.tag, "nohold.cont",  8'(cont2),        8'(t.cont));
            cmp(t.tag, "nohold.count", cnt2,             t.cnt);
        end
    end

    initial begin
        default_data = DEF;
        s_rst = 1'b1; s_phi1 = 1'b0; s_clr = 1'b0; s_rd = 3'b000;
        s_irq_n = 3'b111; s_mask = 3'b111; s_data = {D2, D1, D0};
        reset = 1'b1; phi1 = 1'b0; clear_count = 1'b0; rd_en = 3'b000;
        irq_n_in = 3'b111; irq_mask = 3'b111; card_data = {D2, D1, D0};
        e = '{tag: 0, due: 0, data: 8'h00, oe: 1'b0, grant: 3'b000, irq_n: 1'b1,
              pend: 3'b000, cont: 1'b0, cnt: 8'h00, data2: 8'h00, oe2: 1'b0};

        // Reset state
        step(0, 0);
        step(0, 0);

        // Single card with hold
        s_rst = 1'b0; s_rd = 3'b010;
        e.data = D1; e.oe = 1'b1; e.grant = 3'b010;
        for (int i = 0; i < 5; i++) step(1, 0);
        s_data[15:8] = 8'h3C; e.data = 8'h3C; step(1, 0);
        s_data[15:8] = D1;    e.data = D1;
        for (int i = 0; i < 4; i++) step(1, 0);
        s_rd = 3'b000; e.grant = 3'b000;
        step(1, 1);
        step(1, 1);
        e.oe = 1'b0; e.data = DEF;
        step(1, 0);
        step(1, 0);

        // Priority lock, contention, re-arbitration on phi1
        s_rd = 3'b100; e.data = D2; e.oe = 1'b1; e.grant = 3'b100;
        step(2, 0);
        s_rd = 3'b101; e.cont = 1'b1; e.cnt = 8'd1; step(2, 0);
        e.cnt = 8'd2; step(2, 0);
        s_phi1 = 1'b1; e.grant = 3'b001; e.data = D0; e.cnt = 8'd3; step(2, 0);
        s_phi1 = 1'b0; e.cnt = 8'd4; step(2, 0);
        s_rd = 3'b001; e.cont = 1'b0; step(2, 0);
        s_rd = 3'b000; e.grant = 3'b000;
        step(2, 1);
        step(2, 1);
        e.oe = 1'b0; e.data = DEF;
        step(2, 0);

        // Simultaneous requests, saturation, clear
        s_clr = 1'b1; e.cnt = 8'd0; step(3, 0);
        s_clr = 1'b0; s_rd = 3'b011;
        e.oe = 1'b1; e.data = D0; e.grant = 3'b001; e.cont = 1'b1;
        for (int n = 1; n <= 260; n++) begin
            e.cnt = (n > 255) ? 8'hFF : 8'(n);
            step(3, 0);
        end
        s_clr = 1'b1; e.cnt = 8'd1;
        step(3, 0);
        step(3, 0);
        s_rd = 3'b001; e.cont = 1'b0; e.cnt = 8'd0; step(3, 0);
        s_clr = 1'b0; s_rd = 3'b000; e.grant = 3'b000;
        step(3, 1);
        step(3, 1);
        e.oe = 1'b0; e.data = DEF;
        step(3, 0);

        // Hold abort
        s_rd = 3'b001; e.oe = 1'b1; e.data = D0; e.grant = 3'b001;
        step(4, 0);
        step(4, 0);
        s_rd = 3'b000; e.grant = 3'b000; step(4, 1);
        s_rd = 3'b100; e.grant = 3'b100; e.data = D2;
        step(4, 0);
        step(4, 0);
        s_rd = 3'b000; e.grant = 3'b000;
        step(4, 1);
        step(4, 1);
        e.oe = 1'b0; e.data = DEF;
        step(4, 0);

        // IRQ aggregation and masking
        s_irq_n = 3'b101; e.irq_n = 1'b0; e.pend = 3'b010;
        step(5, 0);
        step(5, 0);
        s_mask = 3'b101; e.irq_n = 1'b1; e.pend = 3'b000; step(5, 0);
        s_irq_n = 3'b010; e.irq_n = 1'b0; e.pend = 3'b101; step(5, 0);
        s_irq_n = 3'b000; s_mask = 3'b111; e.pend = 3'b111; step(5, 0);

        // Reset in the middle of a grant
        s_irq_n = 3'b101; e.pend = 3'b010; e.irq_n = 1'b0;
        s_rd = 3'b010; e.oe = 1'b1; e.data = D1; e.grant = 3'b010;
        step(6, 0);
        s_rd = 3'b011; e.cont = 1'b1; e.cnt = 8'd1; step(6, 0);
        s_rst = 1'b1;
        e = '{tag: 0, due: 0, data: 8'h00, oe: 1'b0, grant: 3'b000, irq_n: 1'b1,
              pend: 3'b000, cont: 1'b0, cnt: 8'h00, data2: 8'h00, oe2: 1'b0};
        step(6, 0);
        s_rst = 1'b0;
        e.data = D0; e.oe = 1'b1; e.grant = 3'b001; e.cont = 1'b1; e.cnt = 8'd1;
        e.irq_n = 1'b0; e.pend = 3'b010;
        step(6, 0);
        s_rd = 3'b000; e.grant = 3'b000; e.cont = 1'b0;
        step(6, 1);
        step(6, 1);
        e.oe = 1'b0; e.data = DEF;
        step(6, 0);

        // Drain the scoreboard with a bounded wait
        for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/a2bus_dout_arbiter.md
Name: a2bus_dout_arbiter

Overview:
Parametrised arbiter for Apple II bus read data and interrupts. It replaces the fixed three-card combinational data mux and IRQ AND in the board top. It accepts NUM_CARDS card read requests, grants one card per bus cycle by fixed priority, and registers the data and output-enable. It adds a post-cycle data hold, bus-contention detection and counting, and per-card maskable IRQ aggregation. It sits between the slot cards and the data IOBUF / IRQ pin.

Parameters:
NUM_CARDS, 3, number of card channels (1..16); index 0 has the highest priority
DATA_WIDTH, 8, card/bus data width
HOLD_CYCLES, 2, clk cycles data_oe_o stays asserted after the granted card drops rd_en (0 = no hold)
CNT_WIDTH, 8, contention counter width
IRQ_ENABLE, 1, 0 forces irq_n_o high

Ports:
clk  in  1  logic clock
reset  in  1  synchronous, active-high reset
phi1_posedge_i  in  1  one-clk pulse marking end of Apple bus cycle (phi0 fall)
card_rd_en_i  in  NUM_CARDS  per-card read request
card_data_i  in  NUM_CARDS*DATA_WIDTH  per-card data; card k occupies bits [k*W +: W]
card_irq_n_i  in  NUM_CARDS  per-card IRQ, active low
irq_mask_i  in  NUM_CARDS  1 = IRQ source enabled
default_data_i  in  DATA_WIDTH  value driven on data_o when no grant
clear_count_i  in  1  clears contention counter
data_o  out  DATA_WIDTH  registered bus data
data_oe_o  out  1  registered output enable to data buffer direction
grant_o  out  NUM_CARDS  one-hot current grant (0 when none)
irq_n_o  out  1  registered aggregate IRQ, active low
irq_pending_o  out  NUM_CARDS  registered masked pending IRQs
contention_o  out  1  one-clk pulse on detected contention
contention_count_o  out  CNT_WIDTH  saturating contention count

Behaviour:
- Reset: state IDLE, data_o=0, data_oe_o=0, grant_o=0, irq_n_o=1, irq_pending_o=0, contention_o=0, contention_count_o=0, hold counter=0.
- FSM states are IDLE, GRANT, HOLD. All outputs are registered, so there is 1 clk latency from input to output.
- IDLE, any rd_en: grant the lowest set index g, go to GRANT. data_oe_o=1, data_o=card_data[g] on the next edge.
- IDLE, no rd_en: data_oe_o=0, data_o=default_data_i.
- GRANT, grant locked: a newly asserted higher-priority rd_en does not preempt. data_o follows card_data[g] each cycle.
- GRANT, rd_en[g] drops:
  - HOLD_CYCLES>0: go to HOLD. Freeze data_o at its last value, keep data_oe_o=1, load counter=HOLD_CYCLES.
  - HOLD_CYCLES=0: go to IDLE.
- GRANT, phi1_posedge_i with rd_en[g] still set: release the lock and re-arbitrate in the same cycle from the current rd_en, staying in GRANT with the new winner. If none is set, go to IDLE.
- HOLD: decrement the counter each clk. At 1→0, go to IDLE and deassert data_oe_o next edge. Total oe extension is exactly HOLD_CYCLES cycles. phi1_posedge_i does not shorten HOLD. Any rd_en during HOLD aborts the hold and grants immediately (as from IDLE) with no contention.
- Contention: contention_o=1 for one cycle when either condition holds:
  - in IDLE/HOLD, two or more rd_en are set in the same cycle;
  - in GRANT, any rd_en other than g is set.
  - Contention is evaluated every cycle, so a persistent conflict pulses every cycle.
- Counter: increments on each contention pulse and saturates at all-ones.
  - clear_count_i alone sets it to 0.
  - clear_count_i together with contention sets it to 1.
- IRQ:
  - pending = ~card_irq_n_i & irq_mask_i, registered into irq_pending_o.
  - irq_n_o = ~|pending, registered; both outputs have 1 clk latency.
  - IRQ_ENABLE=0: irq_n_o held 1, irq_pending_o still valid.
- Widths: NUM_CARDS=1 has no contention possible; the counter never increments.

Test Plan:
- Single card: rd_en[1]=1 with data 8'hA5 for 10 clks, then drop, HOLD_CYCLES=2 -> data_oe_o rises 1 clk later, data_o=A5, grant_o=3'b010. oe stays high exactly 2 clks after the drop-follow edge, then data_o=default_data_i.
- Priority and lock: rd_en[2]=1 (5A), one clk later rd_en[0]=1 (C3) -> grant stays 3'b100, data_o=5A, contention_o pulses each cycle both are set, count increments. Then phi1_posedge_i -> grant 3'b001, data_o=C3.
- Simultaneous requests from IDLE: rd_en=3'b011 -> grant 3'b001, one contention pulse per cycle. Preload count 8'hFF -> stays FF. clear_count_i with contention -> count=1.
- Hold abort: card 0 drops, then card 2 requests on the 1st HOLD cycle -> immediate grant 3'b100, no contention pulse, oe never deasserts.
- IRQ: card_irq_n=3'b101, mask=3'b111 -> irq_pending_o=3'b010, irq_n_o=0 after 1 clk. mask=3'b101 -> irq_n_o=1. IRQ_ENABLE=0 -> irq_n_o=1 always.
- Reset mid-GRANT: assert reset while data_oe_o=1 -> next edge data_oe_o=0, grant_o=0, count=0, irq_n_o=1. After release with rd_en held, grant resumes 1 clk later.
